// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single external memory port: MEM has priority over IF,
// cancelled fetches are drained and discarded, and per-requester wait flags feed the stall logic.
module mem_port_arbiter #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_ack,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_wait,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [WORD_W-1:0] mem_rdata,
    output logic              mem_wait,
    input  logic              halt,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [WORD_W-1:0] ext_wdata,
    input  logic              ext_ready,
    input  logic [WORD_W-1:0] ext_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        DRAIN_IF = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                ext_req_q, ext_req_d;
    logic                ext_we_q, ext_we_d;
    logic [ADDR_W-1:0]   ext_addr_q, ext_addr_d;
    logic [WORD_W-1:0]   ext_wdata_q, ext_wdata_d;

    logic mem_req;
    logic do_arb;
    logic allow_if;
    logic allow_mem;

    assign mem_req = mem_rd | mem_wr;

    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        do_arb      = 1'b0;
        allow_if    = 1'b1;
        allow_mem   = 1'b1;

        // The requester completing this cycle still shows its old request, so it is masked out.
        case (state_q)
            IDLE: do_arb = 1'b1;
            BUSY_IF: begin
                if (ext_ready) begin
                    do_arb   = 1'b1;
                    allow_if = 1'b0;
                end else if (if_cancel) begin
                    state_d = DRAIN_IF;
                end
            end
            BUSY_MEM: begin
                if (ext_ready) begin
                    do_arb    = 1'b1;
                    allow_mem = 1'b0;
                end
            end
            DRAIN_IF: begin
                if (ext_ready) do_arb = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (do_arb) begin
            if (halt) begin
                state_d   = IDLE;
                ext_req_d = 1'b0;
            end else if (allow_mem && mem_req) begin
                state_d     = BUSY_MEM;
                ext_req_d   = 1'b1;
                ext_we_d    = mem_wr;
                ext_addr_d  = mem_addr;
                ext_wdata_d = mem_wdata;
            end else if (allow_if && if_req && !if_cancel) begin
                state_d     = BUSY_IF;
                ext_req_d   = 1'b1;
                ext_we_d    = 1'b0;
                ext_addr_d  = if_addr;
                ext_wdata_d = '0;
            end else begin
                state_d   = IDLE;
                ext_req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q     <= IDLE;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
        end
    end

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

    assign if_ack    = ext_ready && (state_q == BUSY_IF) && !if_cancel;
    assign mem_ack   = ext_ready && (state_q == BUSY_MEM);
    assign if_rdata  = if_ack  ? ext_rdata : '0;
    assign mem_rdata = mem_ack ? ext_rdata : '0;
    assign if_wait   = if_req && !if_ack;
    assign mem_wait  = mem_req && !mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, priority, cancel, halt and async reset scenarios.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        if_req, if_cancel, mem_rd, mem_wr, halt, ext_ready;
    logic [15:0] if_addr, mem_addr, mem_wdata, ext_rdata;
    logic        if_ack, if_wait, mem_ack, mem_wait, ext_req, ext_we;
    logic [15:0] if_rdata, mem_rdata, ext_addr, ext_wdata;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mem_port_arbiter #(.WORD_W(16), .ADDR_W(16)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_wait(if_wait),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .halt(halt),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ready(ext_ready), .ext_rdata(ext_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        Reset_N = 1'b0;
        if_req = 0; if_cancel = 0; mem_rd = 0; mem_wr = 0; halt = 0; ext_ready = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; ext_rdata = '0;

        cyc(); cyc();
        settle();
        chk("rst_ext_req", ext_req, 0);
        chk("rst_ext_we", ext_we, 0);
        chk("rst_ext_addr", ext_addr, 0);
        chk("rst_ext_wdata", ext_wdata, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_mem_ack", mem_ack, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        Reset_N = 1'b1;

        // Single fetch
        cyc(); if_req = 1; if_addr = 16'h0010; settle();
        chk("f1_wait_c2", if_wait, 1);
        chk("f1_noreq_c2", ext_req, 0);
        cyc(); settle();
        chk("f1_req_c3", {ext_req, ext_we, ext_addr}, {2'b10, 16'h0010});
        chk("f1_wait_c3", {if_wait, if_ack}, 2'b10);
        cyc(); settle();
        chk("f1_req_c4", {ext_req, ext_addr}, {1'b1, 16'h0010});
        chk("f1_wait_c4", if_wait, 1);
        cyc(); ext_ready = 1; ext_rdata = 16'hA5A5; settle();
        chk("f1_ack_c5", {if_ack, if_rdata}, {1'b1, 16'hA5A5});
        chk("f1_req_c5", ext_req, 1);
        chk("f1_nowait_c5", if_wait, 0);
        cyc(); if_req = 0; ext_ready = 0; settle();
        chk("f1_idle", {ext_req, if_ack, if_rdata}, 0);

        // Simultaneous requests: MEM first, IF with no bubble
        cyc(); if_req = 1; if_addr = 16'h0020; mem_wr = 1; mem_addr = 16'h0100; mem_wdata = 16'h1234; settle();
        chk("s_waits", {if_wait, mem_wait}, 2'b11);
        cyc(); ext_ready = 1; ext_rdata = 16'h0; settle();
        chk("s_mem_ext", {ext_req, ext_we, ext_addr, ext_wdata}, {2'b11, 16'h0100, 16'h1234});
        chk("s_mem_ack", {mem_ack, if_ack, mem_wait}, 3'b100);
        cyc(); mem_wr = 0; ext_rdata = 16'h005A; settle();
        chk("s_if_ext", {ext_req, ext_we, ext_addr}, {2'b10, 16'h0020});
        chk("s_if_ack", {if_ack, if_rdata, mem_ack}, {1'b1, 16'h005A, 1'b0});
        cyc(); if_req = 0; ext_ready = 0; settle();
        chk("s_idle", ext_req, 0);

        // Cancel mid-fetch: drain until ext_ready, no ack
        cyc(); if_req = 1; if_addr = 16'h0030; settle();
        cyc(); settle();
        chk("c_busy", {ext_req, ext_addr}, {1'b1, 16'h0030});
        cyc(); if_req = 0; if_cancel = 1; settle();
        chk("c_noack_pulse", if_ack, 0);
        cyc(); if_cancel = 0; settle();
        chk("c_drain_req", {ext_req, ext_addr}, {1'b1, 16'h0030});
        cyc(); ext_ready = 1; ext_rdata = 16'hDEAD; settle();
        chk("c_drain_done", {ext_req, if_ack, if_rdata}, {1'b1, 1'b0, 16'h0});
        cyc(); ext_ready = 0; settle();
        chk("c_idle", ext_req, 0);
        cyc(); ext_ready = 1; settle();
        chk("c_idle_ready_ignored", {if_ack, mem_ack, ext_req}, 0);
        cyc(); ext_ready = 0; settle();
        chk("c_idle_stays", ext_req, 0);

        // Cancel coincident with ext_ready, mem_rd pending
        cyc(); if_req = 1; if_addr = 16'h0040; settle();
        cyc(); mem_rd = 1; mem_addr = 16'h0200; ext_ready = 1; if_cancel = 1; ext_rdata = 16'h1111; settle();
        chk("cc_noack", {if_ack, if_rdata}, 0);
        chk("cc_mem_wait", mem_wait, 1);
        cyc(); if_req = 0; if_cancel = 0; ext_ready = 0; settle();
        chk("cc_mem_grant", {ext_req, ext_we, ext_addr}, {2'b10, 16'h0200});
        cyc(); ext_ready = 1; ext_rdata = 16'h0077; settle();
        chk("cc_mem_ack", {mem_ack, mem_rdata}, {1'b1, 16'h0077});
        cyc(); mem_rd = 0; ext_ready = 0; settle();
        chk("cc_idle", ext_req, 0);

        // Halt during BUSY_MEM with if_req pending
        cyc(); mem_rd = 1; mem_addr = 16'h0300; if_req = 1; if_addr = 16'h0050; settle();
        cyc(); halt = 1; settle();
        chk("h_busy", {ext_req, ext_addr}, {1'b1, 16'h0300});
        cyc(); ext_ready = 1; ext_rdata = 16'h0099; settle();
        chk("h_mem_ack", {mem_ack, mem_rdata}, {1'b1, 16'h0099});
        cyc(); mem_rd = 0; ext_ready = 0; settle();
        chk("h_no_grant1", {ext_req, if_wait}, 2'b01);
        cyc(); settle();
        chk("h_no_grant2", ext_req, 0);
        halt = 0;
        cyc(); settle();
        chk("h_if_grant", {ext_req, ext_addr}, {1'b1, 16'h0050});
        ext_ready = 1; ext_rdata = 16'h0042; #1;
        chk("h_if_ack", {if_ack, if_rdata}, {1'b1, 16'h0042});
        cyc(); if_req = 0; ext_ready = 0; settle();
        chk("h_idle", ext_req, 0);

        // Write+read both high: write wins; then async reset mid-access
        cyc(); mem_wr = 1; mem_rd = 1; mem_addr = 16'h0400; mem_wdata = 16'hBEEF; settle();
        cyc(); settle();
        chk("r_busy", {ext_req, ext_we, ext_addr, ext_wdata}, {2'b11, 16'h0400, 16'hBEEF});
        ext_ready = 1; #1;
        chk("r_ack_before", mem_ack, 1);
        Reset_N = 0; #1;
        chk("r_async_req", {ext_req, ext_we, ext_addr, ext_wdata}, 0);
        chk("r_async_ack", {mem_ack, mem_rdata}, 0);
        ext_ready = 0; mem_wr = 0; mem_rd = 0;
        cyc(); Reset_N = 1; settle();
        cyc(); ext_ready = 1; settle();
        chk("r_late_ready", {mem_ack, if_ack, ext_req}, 0);
        cyc(); ext_ready = 0; settle();
        chk("r_idle", ext_req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
